nabp_sinogram_buffer: RTL and testbench
=======================================

Name: nabp_sinogram_buffer

Overview:
- Sinogram storage responder on the NABP read interface. It sits between the host and the NABP core.
- Host side: accepts a streamed sinogram (valid/ready, with a last marker) and writes it sequentially into an internal RAM.
- NABP side: serves sg_addr -> sg_val reads with fixed one-cycle latency.
- Tracks the host kick/done handshake and locks out writes while a reconstruction is running.

Parameters:
- SG_DATA_WIDTH, 8, width of one sinogram sample.
- SG_ADDR_WIDTH, 10, sinogram address width.
- SG_DEPTH, 1024, number of samples in one sinogram; must be <= 2^SG_ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  host sample valid.
- wr_data  in  SG_DATA_WIDTH  host sample.
- wr_last  in  1  marks the final sample of a sinogram.
- wr_ready  out  1  buffer accepts a sample this cycle.
- loaded  out  1  level; a complete sinogram is resident.
- load_error  out  1  one-cycle pulse on a length mismatch.
- kick  in  1  host start pulse (same signal that drives NABP).
- done  in  1  NABP completion pulse.
- sg_addr  in  SG_ADDR_WIDTH  NABP read address.
- sg_val  out  SG_DATA_WIDTH  read data, registered.
- busy  out  1  reconstruction in progress; buffer is read-only.

Behaviour:
- Single clock, clk. reset is synchronous and active-high.
- Reset values: wr_ready=0, loaded=0, load_error=0, busy=0, sg_val=0, write pointer=0, state=EMPTY. RAM contents are not cleared.
- FSM states: EMPTY, LOADING, LOADED, BUSY.
- EMPTY: wr_ready=1. The first accepted beat (wr_valid && wr_ready) writes address 0 and moves to LOADING, or to LOADED if it is a legal single-beat sinogram (SG_DEPTH=1 with wr_last).
- LOADING: wr_ready=1. Each accepted beat writes RAM[ptr] and increments ptr.
  - wr_last on beat index SG_DEPTH-1: go to LOADED, ptr=0.
  - wr_last earlier than index SG_DEPTH-1: pulse load_error, discard the load, go to EMPTY, ptr=0.
  - Beat SG_DEPTH-1 arrives without wr_last: pulse load_error, go to EMPTY, ptr=0. There is no wrap-around write.
- LOADED: loaded=1, wr_ready=0. kick moves to BUSY on the next cycle. wr_valid is ignored (back-pressured).
- BUSY: busy=1, loaded=1, wr_ready=0. done returns to LOADED, so the same sinogram can be re-kicked. kick during BUSY is ignored.
- kick in EMPTY or LOADING: ignored, no state change. NABP then reads stale data; the host is responsible.
- kick and done in the same cycle while BUSY: done wins, go to LOADED.
- Host reload: a wr_valid beat is accepted only in EMPTY/LOADING. Any load_error returns to EMPTY. There is no explicit flush; reset is the flush.
- Read path: sg_val <= RAM[sg_addr] every cycle, in all states, with 1-cycle latency.
  - sg_addr >= SG_DEPTH returns 0.
  - A read and a write to the same address in the same cycle (possible only if NABP reads during LOADING) returns the old data (read-first).
- Reset mid-load or mid-BUSY: return to EMPTY immediately and drop loaded and busy. Pending wr_valid is not accepted in the reset cycle.

Optional Feature:
- Macro: NABP_SG_BUFFER_PARITY_EN.
- When defined:
  - RAM width is SG_DATA_WIDTH+1; each write stores the even parity of wr_data.
  - Each read recomputes parity, and a mismatch raises an extra output port, parity_error (1 bit), for the cycle sg_val is valid.
  - parity_error resets to 0.
- When undefined: no parity storage, no parity_error port, RAM width = SG_DATA_WIDTH.

Decomposition:
- Shared package nabp_sg_pkg holds:
  - FSM state enum (EMPTY, LOADING, LOADED, BUSY);
  - default SG_DATA_WIDTH/SG_ADDR_WIDTH/SG_DEPTH constants;
  - the parity function.
- One sub-module, nabp_sg_ram:
  - single clock, one write port and one read port;
  - registered read, read-first semantics;
  - width parameterised for the parity option;
  - infers block RAM.
- The FSM, write pointer and length checking stay in the top module.

Test Plan:
- Normal load: SG_DEPTH=16, stream samples 0x10..0x1F with wr_last on the 16th -> loaded=1 the cycle after the last beat; wr_ready=0; reading sg_addr=5 gives sg_val=0x15 one cycle later.
- Short load: wr_last on the 10th beat of 16 -> load_error pulses 1 cycle, state EMPTY, loaded=0, wr_ready=1; a full reload then succeeds.
- Missing last: 16 beats with no wr_last -> load_error on beat 16; a 17th wr_valid is accepted as address 0 of a new load.
- Kick/done: after load, kick -> busy=1 next cycle; a kick in BUSY is ignored; done -> busy=0, loaded=1; a second kick -> busy=1 again.
- Write lock: wr_valid held high with data 0xAA during BUSY -> wr_ready=0 throughout; RAM unchanged (sg_addr=0 still reads 0x10). Out-of-range sg_addr=20 -> sg_val=0.
- Reset mid-BUSY, plus parity: assert reset during BUSY -> busy=0, loaded=0, wr_ready=1 next cycle. With NABP_SG_BUFFER_PARITY_EN, force a stored parity bit flip at address 3 -> parity_error=1 exactly in the cycle sg_val for address 3 is presented.

Source files
------------

// File: rtl/nabp_sg_pkg.sv
// Shared definitions for the NABP sinogram buffer: FSM states, default
// geometry and the parity helper used by the optional parity build
// (NABP_SG_BUFFER_PARITY_EN).
package nabp_sg_pkg;

  localparam int unsigned SG_DATA_WIDTH_DEF = 8;
  localparam int unsigned SG_ADDR_WIDTH_DEF = 10;
  localparam int unsigned SG_DEPTH_DEF      = 1024;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_LOADED  = 2'd2,
    ST_BUSY    = 2'd3
  } sg_state_e;

  // XOR reduction; callers zero-extend (width <= 32), which leaves parity unchanged
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/nabp_sg_ram.sv
// Single-clock sinogram RAM: one write port, one registered read-first read
// port. Reads at or beyond DEPTH return zero.
module nabp_sg_ram
  import nabp_sg_pkg::*;
#(
  parameter int unsigned WIDTH  = SG_DATA_WIDTH_DEF,
  parameter int unsigned ADDR_W = SG_ADDR_WIDTH_DEF,
  parameter int unsigned DEPTH  = SG_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  // Storage covers the full address space so any raddr indexes legally
  localparam int unsigned NWORDS = 32'd1 << ADDR_W;

  logic [WIDTH-1:0] mem [NWORDS];
  logic [WIDTH-1:0] rdata_d, rdata_q;
  logic             in_range;

  // Range-check the read address and fetch the old word
  always_comb begin
    in_range = ({1'b0, raddr} < (ADDR_W+1)'(DEPTH));
    rdata_d  = '0;
    if (in_range) begin
      rdata_d = mem[raddr];
    end
  end

  // Memory array write; contents are never cleared
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read data, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/nabp_sinogram_buffer.sv
// Sinogram buffer between host and NABP core: sequential host load with
// length checking, one-cycle NABP read port, kick/done tracking that locks
// out writes while a reconstruction runs.
// Optional: define NABP_SG_BUFFER_PARITY_EN to store a parity bit per sample
// and flag read-side parity mismatches on parity_error.
// SG_DEPTH must not exceed 2**SG_ADDR_WIDTH.
module nabp_sinogram_buffer
  import nabp_sg_pkg::*;
#(
  parameter int unsigned SG_DATA_WIDTH = SG_DATA_WIDTH_DEF,
  parameter int unsigned SG_ADDR_WIDTH = SG_ADDR_WIDTH_DEF,
  parameter int unsigned SG_DEPTH      = SG_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [SG_DATA_WIDTH-1:0] wr_data,
  input  logic                     wr_last,
  output logic                     wr_ready,
  output logic                     loaded,
  output logic                     load_error,
  input  logic                     kick,
  input  logic                     done,
  input  logic [SG_ADDR_WIDTH-1:0] sg_addr,
  output logic [SG_DATA_WIDTH-1:0] sg_val,
`ifdef NABP_SG_BUFFER_PARITY_EN
  output logic                     parity_error,
`endif
  output logic                     busy
);

`ifdef NABP_SG_BUFFER_PARITY_EN
  localparam int unsigned RAM_W = SG_DATA_WIDTH + 1;
`else
  localparam int unsigned RAM_W = SG_DATA_WIDTH;
`endif

  localparam logic [SG_ADDR_WIDTH-1:0] LAST_IDX = SG_ADDR_WIDTH'(SG_DEPTH - 1);

  sg_state_e                state_d, state_q;
  logic [SG_ADDR_WIDTH-1:0] ptr_d, ptr_q;
  logic                     wr_ready_d, wr_ready_q;
  logic                     loaded_d, loaded_q;
  logic                     busy_d, busy_q;
  logic                     load_error_d, load_error_q;
  logic                     wr_fire;
  logic [RAM_W-1:0]         ram_wdata;
  logic [RAM_W-1:0]         ram_rdata;

  // A beat is taken only while ready and never in a reset cycle
  assign wr_fire = wr_valid & wr_ready_q & ~reset;

`ifdef NABP_SG_BUFFER_PARITY_EN
  assign ram_wdata = {even_parity(32'(wr_data)), wr_data};
`else
  assign ram_wdata = wr_data;
`endif

  // Next-state, write pointer and length checking
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_error_d = 1'b0;
    case (state_q)
      ST_EMPTY, ST_LOADING: begin
        if (wr_fire) begin
          if (ptr_q == LAST_IDX) begin
            ptr_d = '0;
            if (wr_last) begin
              state_d = ST_LOADED;
            end else begin
              load_error_d = 1'b1;
              state_d      = ST_EMPTY;
            end
          end else if (wr_last) begin
            load_error_d = 1'b1;
            state_d      = ST_EMPTY;
            ptr_d        = '0;
          end else begin
            state_d = ST_LOADING;
            ptr_d   = ptr_q + SG_ADDR_WIDTH'(1);
          end
        end
      end
      ST_LOADED: begin
        if (kick) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d = ST_LOADED;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    wr_ready_d = (state_d == ST_EMPTY) || (state_d == ST_LOADING);
    loaded_d   = (state_d == ST_LOADED) || (state_d == ST_BUSY);
    busy_d     = (state_d == ST_BUSY);
  end

  // State, pointer and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      ptr_q        <= '0;
      wr_ready_q   <= 1'b0;
      loaded_q     <= 1'b0;
      busy_q       <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wr_ready_q   <= wr_ready_d;
      loaded_q     <= loaded_d;
      busy_q       <= busy_d;
      load_error_q <= load_error_d;
    end
  end

  nabp_sg_ram #(
    .WIDTH  (RAM_W),
    .ADDR_W (SG_ADDR_WIDTH),
    .DEPTH  (SG_DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_fire),
    .waddr (ptr_q),
    .wdata (ram_wdata),
    .raddr (sg_addr),
    .rdata (ram_rdata)
  );

  assign wr_ready   = wr_ready_q;
  assign loaded     = loaded_q;
  assign busy       = busy_q;
  assign load_error = load_error_q;
  assign sg_val     = ram_rdata[SG_DATA_WIDTH-1:0];

`ifdef NABP_SG_BUFFER_PARITY_EN
  // Stored word includes its even-parity bit, so a good word reduces to 0
  assign parity_error = even_parity(32'(ram_rdata));
`endif

endmodule

// File: tb/tb_nabp_sinogram_buffer.sv
// Self-checking bench for nabp_sinogram_buffer (16-sample sinogram).
module tb_nabp_sinogram_buffer;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NVEC  = 11;

  logic          clk;
  logic          reset;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          wr_ready;
  logic          loaded;
  logic          load_error;
  logic          kick;
  logic          done;
  logic [AW-1:0] sg_addr;
  logic [DW-1:0] sg_val;
  logic          busy;
`ifdef NABP_SG_BUFFER_PARITY_EN
  logic          parity_error;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          rst;
    logic          wv;
    logic [DW-1:0] wd;
    logic          kick;
    logic          done;
    logic [AW-1:0] addr;
    logic          e_ready;
    logic          e_loaded;
    logic          e_busy;
    logic          e_err;
    logic [DW-1:0] e_val;
  } vec_t;

  vec_t vecs [NVEC];

  nabp_sinogram_buffer #(
    .SG_DATA_WIDTH (DW),
    .SG_ADDR_WIDTH (AW),
    .SG_DEPTH      (DEPTH)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .wr_ready     (wr_ready),
    .loaded       (loaded),
    .load_error   (load_error),
    .kick         (kick),
    .done         (done),
    .sg_addr      (sg_addr),
    .sg_val       (sg_val),
`ifdef NABP_SG_BUFFER_PARITY_EN
    .parity_error (parity_error),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic e_ready, input logic e_loaded,
                              input logic e_busy, input logic e_err);
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'(e_ready));
    check({tag, "_loaded"}, 32'(loaded), 32'(e_loaded));
    check({tag, "_busy"}, 32'(busy), 32'(e_busy));
    check({tag, "_load_error"}, 32'(load_error), 32'(e_err));
  endtask

  initial begin
    // rst wv wd kick done addr | ready loaded busy err val   (state LOADED, RAM 0x10..0x1F)
    vecs[0]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h10};
    vecs[1]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'h10};
    vecs[2]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 5'd1,  1'b0, 1'b1, 1'b1, 1'b0, 8'h11};
    vecs[3]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 5'd20, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd15, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1F};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'h10};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd2,  1'b0, 1'b1, 1'b0, 1'b0, 8'h12};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd3,  1'b0, 1'b1, 1'b1, 1'b0, 8'h13};
    vecs[8]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'h10};
    vecs[9]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 8'h14};

    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_last  = 1'b0;
    kick     = 1'b0;
    done     = 1'b0;
    sg_addr  = '0;

    // Reset state
    tick();
    tick();
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_sg_val", 32'(sg_val), 32'h0);
`ifdef NABP_SG_BUFFER_PARITY_EN
    check("reset_parity_error", 32'(parity_error), 32'h0);
`endif
    reset = 1'b0;
    tick();
    check_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);

    // Normal load 0x10..0x1F
    for (int i = 0; i < int'(DEPTH); i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(16 + i);
      wr_last  = (i == int'(DEPTH) - 1);
      tick();
      if (i == 7) check_status("load_mid", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    check_status("load_done", 1'b0, 1'b1, 1'b0, 1'b0);
    sg_addr = 5'd5;
    tick();
    check("load_read5", 32'(sg_val), 32'h15);

    // Kick/done, write lock, out-of-range read, reset mid-BUSY
    for (int i = 0; i < int'(NVEC); i++) begin
      reset    = vecs[i].rst;
      wr_valid = vecs[i].wv;
      wr_data  = vecs[i].wd;
      kick     = vecs[i].kick;
      done     = vecs[i].done;
      sg_addr  = vecs[i].addr;
      tick();
      check_status($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_loaded,
                   vecs[i].e_busy, vecs[i].e_err);
      check($sformatf("vec%0d_sg_val", i), 32'(sg_val), 32'(vecs[i].e_val));
    end
    reset    = 1'b0;
    wr_valid = 1'b0;
    kick     = 1'b0;
    done     = 1'b0;

    // Short load: wr_last on 10th beat, RAM keeps the partial data
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(8'h40 + i);
      wr_last  = (i == 9);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    check_status("short_err", 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check_status("short_after", 1'b1, 1'b0, 1'b0, 1'b0);

    // Full reload with a read-first collision at address 2
    sg_addr = 5'd2;
    for (int i = 0; i < int'(DEPTH); i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(8'h60 + i);
      wr_last  = (i == int'(DEPTH) - 1);
      tick();
      if (i == 2) check("rf_old_data", 32'(sg_val), 32'h42);
      if (i == 3) check("rf_new_data", 32'(sg_val), 32'h62);
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    check_status("reload_done", 1'b0, 1'b1, 1'b0, 1'b0);
    sg_addr = 5'd9;
    tick();
    check("reload_read9", 32'(sg_val), 32'h69);

    // Missing last: error on beat 16, next beat starts a new load at address 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < int'(DEPTH); i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(8'h80 + i);
      tick();
    end
    check_status("nolast_err", 1'b1, 1'b0, 1'b0, 1'b1);
    wr_data = 8'h99;
    sg_addr = 5'd0;
    tick();
    check_status("beat17", 1'b1, 1'b0, 1'b0, 1'b0);
    check("beat17_old_val", 32'(sg_val), 32'h80);
    wr_valid = 1'b0;
    kick     = 1'b1;
    tick();
    kick = 1'b0;
    check_status("kick_loading", 1'b1, 1'b0, 1'b0, 1'b0);
    check("beat17_new_val", 32'(sg_val), 32'h99);

`ifdef NABP_SG_BUFFER_PARITY_EN
    // Corrupt the stored parity bit of address 3
    u_dut.u_ram.mem[3][DW] = ~u_dut.u_ram.mem[3][DW];
    sg_addr = 5'd2;
    tick();
    check("par_ok_before", 32'(parity_error), 32'h0);
    sg_addr = 5'd3;
    tick();
    check("par_err_val", 32'(sg_val), 32'h83);
    check("par_err_flag", 32'(parity_error), 32'h1);
    sg_addr = 5'd4;
    tick();
    check("par_ok_after", 32'(parity_error), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
